// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing for the display path. It divides the
// system clock into a pixel strobe, keeps the h/v counters, and decodes the
// sync pulses and the active-video flag with no skew against the counters.
// Optional feature macro: VGA_SCROLL_PHASE_EN adds the ground-stripe scroll
// phase. That phase steps every SCROLL_FRAMES frames while the game is playing.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SCROLL_FRAMES = 2,
    parameter int unsigned SCROLL_PERIOD = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    output logic [10:0] hcounter,
    output logic [10:0] vcounter,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        pix_en,
    output logic        frame_start,
    output logic [4:0]  scroll_phase
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [10:0]      h_nxt;
    logic [10:0]      v_nxt;
    logic             frame_wrap;

    // Next divider and raster position; decodes are taken from these so they track the counters
    always_comb begin
        div_nxt    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        h_nxt      = hcounter;
        v_nxt      = vcounter;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (hcounter == H_LAST) begin
                h_nxt = '0;
                if (vcounter == V_LAST) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vcounter + 11'd1;
                end
            end else begin
                h_nxt = hcounter + 11'd1;
            end
        end
    end

    // Pixel divider, raster counters and registered decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hcounter    <= '0;
            vcounter    <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_en      <= (div_nxt == DIV_LAST);
            hcounter    <= h_nxt;
            vcounter    <= v_nxt;
            hsync       <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
            vsync       <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
            video_on    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_SCROLL_PHASE_EN
    localparam int unsigned FC_W    = $clog2(SCROLL_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(SCROLL_FRAMES - 1);
    localparam logic [4:0]      SP_LAST = 5'(SCROLL_PERIOD - 1);
    localparam logic [2:0]      PLAYING = 3'b011;

    logic [FC_W-1:0] frame_cnt;

    // Frame counter and scroll phase; only frames that start while playing count
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt    <= '0;
            scroll_phase <= '0;
        end else if (frame_start && (state == PLAYING)) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt    <= '0;
                scroll_phase <= (scroll_phase == SP_LAST) ? 5'd0 : scroll_phase + 5'd1;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end
`else
    logic unused_state;

    // Scroll feature absent: phase pinned at zero and the game state is ignored
    assign scroll_phase = 5'd0;
    assign unused_state = ^state;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken raster. Line: 16 pixels
// (8 active, hsync pixels 10..12). Frame: 8 lines (4 active, vsync lines 5..6).
// CLK_DIV is 4, so a line is 64 clk and a frame is 512 clk.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic [10:0] hcounter;
    logic [10:0] vcounter;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        pix_en;
    logic        frame_start;
    logic [4:0]  scroll_phase;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n = 0;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(4), .SCROLL_FRAMES(2), .SCROLL_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .state(state),
        .hcounter(hcounter),
        .vcounter(vcounter),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .pix_en(pix_en),
        .frame_start(frame_start),
        .scroll_phase(scroll_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int unsigned target);
        while (n < target) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_h"}, 32'(hcounter), 32'd0);
        check({tag, "_v"}, 32'(vcounter), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_video_on"}, 32'(video_on), 32'd1);
        check({tag, "_pix_en"}, 32'(pix_en), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_scroll"}, 32'(scroll_phase), 32'd0);
    endtask

    // Expected raster at cycle n after release: pixel index p = n/4
    task automatic check_raster();
        int unsigned p;
        int unsigned h;
        int unsigned v;
        p = n / 4;
        h = p % 16;
        v = (p / 16) % 8;
        check("sweep_h", 32'(hcounter), h);
        check("sweep_v", 32'(vcounter), v);
        check("sweep_hsync", 32'(hsync), (h >= 10 && h < 13) ? 32'd0 : 32'd1);
        check("sweep_vsync", 32'(vsync), (v >= 5 && v < 7) ? 32'd0 : 32'd1);
        check("sweep_video_on", 32'(video_on), (h < 8 && v < 4) ? 32'd1 : 32'd0);
        check("sweep_pix_en", 32'(pix_en), (n % 4 == 3) ? 32'd1 : 32'd0);
        check("sweep_frame_start", 32'(frame_start), (n != 0 && n % 512 == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int unsigned hs_cnt;
        int unsigned hs_first;
        int unsigned vs_cnt;
        int unsigned vs_first_v;
        int unsigned fs_cnt;
        int unsigned fs_prev;
        int unsigned fs_gap;

        hs_cnt = 0; hs_first = 999; vs_cnt = 0; vs_first_v = 999;
        fs_cnt = 0; fs_prev = 0; fs_gap = 0;

        // Reset held for three edges
        rst   = 1'b1;
        state = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        // Release: first pix_en in cycle 3
        rst = 1'b0;
        n   = 0;
        check("rel_pix_en_c0", 32'(pix_en), 32'd0);
        step();
        check("rel_pix_en_c1", 32'(pix_en), 32'd0);
        step();
        check("rel_pix_en_c2", 32'(pix_en), 32'd0);
        check("rel_frame_start_c2", 32'(frame_start), 32'd0);
        step();
        check("rel_pix_en_c3", 32'(pix_en), 32'd1);
        check("rel_h_c3", 32'(hcounter), 32'd0);
        step();
        check("rel_h_c4", 32'(hcounter), 32'd1);
        check("rel_pix_en_c4", 32'(pix_en), 32'd0);

        // Two full frames cycle by cycle with directed spot checks
        while (n < 1030) begin
            check_raster();
            if (n >= 64 && n < 128 && pix_en && !hsync) begin
                if (hs_cnt == 0) hs_first = 32'(hcounter);
                hs_cnt++;
            end
            if (n < 512 && pix_en && !vsync) begin
                if (vs_cnt == 0) vs_first_v = 32'(vcounter);
                vs_cnt++;
            end
            if (frame_start) begin
                if (fs_cnt > 0) fs_gap = n - fs_prev;
                fs_prev = n;
                fs_cnt++;
            end
            if (n == 127) begin
                check("line_end_h", 32'(hcounter), 32'd15);
                check("line_end_v", 32'(vcounter), 32'd1);
                check("line_end_pix_en", 32'(pix_en), 32'd1);
            end
            if (n == 128) begin
                check("line_wrap_h", 32'(hcounter), 32'd0);
                check("line_wrap_v", 32'(vcounter), 32'd2);
            end
            if (n == 511) begin
                check("frame_end_h", 32'(hcounter), 32'd15);
                check("frame_end_v", 32'(vcounter), 32'd7);
            end
            if (n == 512) begin
                check("frame_wrap_h", 32'(hcounter), 32'd0);
                check("frame_wrap_v", 32'(vcounter), 32'd0);
                check("frame_wrap_fs", 32'(frame_start), 32'd1);
            end
            if (n == 513) check("frame_fs_one_clk", 32'(frame_start), 32'd0);
            step();
        end
        check("hsync_width", hs_cnt, 32'd3);
        check("hsync_first_h", hs_first, 32'd10);
        check("vsync_pixels", vs_cnt, 32'd32);
        check("vsync_first_v", vs_first_v, 32'd5);
        check("frame_start_count", fs_cnt, 32'd2);
        check("frame_start_gap", fs_gap, 32'd512);
        check("scroll_idle", 32'(scroll_phase), 32'd0);

`ifdef VGA_SCROLL_PHASE_EN
        // Playing from frame_start at n=1536; pulse 10 lands at n=6144
        state = 3'b011;
        run_to(6144);
        check("scroll_fs_10", 32'(frame_start), 32'd1);
        check("scroll_pre_wrap", 32'(scroll_phase), 32'd4);
        step();
        check("scroll_wrap", 32'(scroll_phase), 32'd0);
        run_to(7169);
        check("scroll_after_12", 32'(scroll_phase), 32'd1);
        state = 3'b000;
        run_to(8705);
        check("scroll_hold", 32'(scroll_phase), 32'd1);
        // Enter playing exactly on the frame_start cycle: both such frames count
        run_to(9216);
        check("toggle_fs_a", 32'(frame_start), 32'd1);
        state = 3'b011;
        step();
        state = 3'b000;
        check("toggle_a_phase", 32'(scroll_phase), 32'd1);
        run_to(9728);
        check("toggle_fs_b", 32'(frame_start), 32'd1);
        state = 3'b011;
        step();
        state = 3'b000;
        check("toggle_b_phase", 32'(scroll_phase), 32'd2);
`else
        state = 3'b011;
        run_to(9729);
        check("scroll_tied", 32'(scroll_phase), 32'd0);
        state = 3'b000;
`endif

        // Mid-frame reset at (5,2) with the divider mid-count
        run_to(9878);
        check("pre_mid_h", 32'(hcounter), 32'd5);
        check("pre_mid_v", 32'(vcounter), 32'd2);
        rst = 1'b1;
        step();
        check_reset_vals("midrst");
        rst = 1'b0;
        n   = 0;
        check("mid_pix_en_c0", 32'(pix_en), 32'd0);
        step();
        step();
        check("mid_pix_en_c2", 32'(pix_en), 32'd0);
        step();
        check("mid_pix_en_c3", 32'(pix_en), 32'd1);
        step();
        while (n < 200) begin
            check_raster();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
